// File: rtl/la_cellbist_pkg.sv
// Shared types and constants for the la_cellbist4 four-input cell self-test driver.
package la_cellbist_pkg;

   // Sweep sequencer states. The sequencer exports its current state on a debug port.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One sweep applies every combination of the four cell inputs.
   localparam int PAT_CNT = 16;
   localparam int IDX_W   = 4;

   // Holds 0..PAT_CNT, so the count cannot wrap.
   localparam int ERR_W   = 5;

endpackage

// File: rtl/la_cellbist_seq.sv
// Sweep sequencer for la_cellbist4. It holds the state register, the pattern
// index, the settle wait counter and the registered cell drive pattern.
//
// start handshake: start is a single-cycle request. It is accepted on a rising
// edge only while busy is 0 (IDLE or DONE). A start seen while busy is dropped;
// it is neither queued nor does it restart the sweep.
module la_cellbist_seq
   import la_cellbist_pkg::*;
#(
   parameter int SETTLE = 2   // drive cycles before the check cycle, 1..15
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output state_t           state,   // debug view of the sequencer state
   output logic [IDX_W-1:0] idx,
   output logic [3:0]       pat,     // {b0,a2,a1,a0}
   output logic             busy,
   output logic             done
);

   localparam logic [3:0]       SETTLE_W = 4'(SETTLE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_CNT - 1);

   logic [3:0] wait_cnt;

   // Sweep FSM: each pattern spends SETTLE cycles in DRIVE and one in CHECK.
   // All outputs are registers so the cell pins never glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         idx      <= '0;
         wait_cnt <= '0;
         pat      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_DRIVE;
                  idx      <= '0;
                  wait_cnt <= 4'd1;
                  pat      <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            ST_DRIVE: begin
               if (wait_cnt == SETTLE_W) begin
                  state <= ST_CHECK;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            ST_CHECK: begin
               if (idx == LAST_IDX) begin
                  state <= ST_DONE;
                  pat   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state    <= ST_DRIVE;
                  idx      <= idx + 4'd1;
                  wait_cnt <= 4'd1;
                  pat      <= idx + 4'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/la_cellbist4.sv
// la_cellbist4: sequential self-test driver for four-input, one-output cells.
// Drives all 16 input patterns, samples z at the end of each check cycle,
// compares against TRUTH (bit index {b0,a2,a1,a0}) and reports the mismatch
// count and pass/fail.
// Optional feature macro: LA_CELLBIST_FAILLOG_EN adds a first-failure log
// (fail_vld, fail_idx, fail_z).
module la_cellbist4
   import la_cellbist_pkg::*;
#(
   parameter string       PROP   = "DEFAULT",   // implementation property, passed through
   parameter logic [15:0] TRUTH  = 16'hFE00,    // default: (a0|a1|a2)&b0
   parameter int          SETTLE = 2            // legal range 1..15
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             z,
   output logic             a0,
   output logic             a1,
   output logic             a2,
   output logic             b0,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
`ifdef LA_CELLBIST_FAILLOG_EN
   ,
   output logic             fail_vld,
   output logic [3:0]       fail_idx,
   output logic             fail_z
`endif
);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [3:0]       pat;
   logic             launch;
   logic             check;
   logic             mism;

   la_cellbist_seq #(
      .SETTLE (SETTLE)
   ) u_seq (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .state (state),
      .idx   (idx),
      .pat   (pat),
      .busy  (busy),
      .done  (done)
   );

   assign {b0, a2, a1, a0} = pat;

   // A sweep is accepted exactly when the sequencer is not busy.
   assign launch = start & ~busy;
   assign check  = (state == ST_CHECK);
   // z only matters in CHECK; gating first keeps an unknown z harmless elsewhere.
   assign mism   = check & (z != TRUTH[idx]);

   // Mismatch counter: cleared at sweep launch, bumped after each failing check.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (launch) begin
         err_cnt <= '0;
      end else if (mism) begin
         err_cnt <= err_cnt + ERR_W'(1);
      end
   end

   assign pass = done & (err_cnt == '0);

`ifdef LA_CELLBIST_FAILLOG_EN
   // First-failure capture: later mismatches never overwrite the log.
   always_ff @(posedge clk) begin
      if (reset) begin
         fail_vld <= 1'b0;
         fail_idx <= '0;
         fail_z   <= 1'b0;
      end else if (launch) begin
         fail_vld <= 1'b0;
         fail_idx <= '0;
         fail_z   <= 1'b0;
      end else if (mism && !fail_vld) begin
         fail_vld <= 1'b1;
         fail_idx <= idx;
         fail_z   <= z;
      end
   end
`endif

endmodule

// File: doc/la_cellbist4.md
# la_cellbist4

Sequential built-in self-test driver for four-input, one-output standard cells such as the or-and family. It drives all 16 input patterns into a cell under test and samples the cell's output after a programmable settle time. Each sample is compared against a parameterized truth table, and the block reports mismatch count and pass/fail. It sits beside stdlib cells in test wrappers and silicon characterization harnesses, acting as the stimulus and checking end of the cell's pins.

## Interface
- PROP, "DEFAULT", implementation property string, passed through unchanged
- TRUTH, 16'hFE00, expected output per pattern; bit index = {b0,a2,a1,a0}; default encodes (a0|a1|a2)&b0
- SETTLE, 2, cycles each pattern is driven before sampling; legal range 1..15

- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to run a full sweep
- z  input  1  output of cell under test
- a0, a1, a2, b0  output  1 each  drive to cell under test, registered
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held until next start or reset
- pass  output  1  valid when done; 1 iff err_cnt == 0
- err_cnt  output  5  mismatch count, range 0..16, no wrap
- fail_vld, fail_idx[3:0], fail_z  output  only with LA_CELLBIST_FAILLOG_EN (see Configuration)

## Operation
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`.
- States:
  - IDLE: drive outputs 0, busy=0.
  - DRIVE: apply pattern idx, wait SETTLE cycles.
  - CHECK: hold pattern, sample z.
  - DONE: drive outputs 0, done=1.
- Transitions:
  - IDLE --start--> DRIVE: idx=0, err_cnt=0, done=0.
  - DRIVE: wait counter counts 1..SETTLE, then --> CHECK.
  - CHECK: if z != TRUTH[idx], err_cnt+1.
  - CHECK, idx<15 --> DRIVE with idx+1. CHECK, idx==15 --> DONE.
  - DONE --start--> DRIVE: full restart; counters and done clear.
- {b0,a2,a1,a0} = idx throughout DRIVE and CHECK of that pattern.
- start while busy is ignored; no restart, no queuing.
- err_cnt is 5 bits, so its maximum of 16 cannot overflow.
- pass = done & (err_cnt == 0); pass is 0 whenever done = 0.
- z is sampled at the end of the CHECK cycle only. z is don't-care in every other state, including X.

## Timing
- Reset values: state IDLE, a0/a1/a2/b0=0, busy=0, done=0, pass=0, err_cnt=0, fail_* = 0.
- Reset asserted mid-sweep: state returns to IDLE on the next edge and all outputs return to reset values. The partial result is discarded.
- Start on edge T: busy=1 and pattern 0 is driven from T+1.
- Each pattern occupies SETTLE+1 cycles.
- done rises at T+1+16·(SETTLE+1), i.e. T+49 for SETTLE=2. busy falls in the same cycle.
- err_cnt updates in the cycle after the CHECK in which the mismatch is sampled.
- Drive outputs change only on a DRIVE entry, or on a DONE/IDLE entry (to 0). They are glitch-free registered outputs.

## Configuration
- LA_CELLBIST_FAILLOG_EN defined:
  - Adds fail_vld, fail_idx[3:0] and fail_z.
  - They capture the first mismatching pattern index and the observed z.
  - fail_vld stays 1 until the next start or reset. Later mismatches do not overwrite the capture.
- LA_CELLBIST_FAILLOG_EN not defined: those ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package la_cellbist_pkg holds:
  - state enum (IDLE, DRIVE, CHECK, DONE);
  - pattern count constant 16;
  - err_cnt width constant 5.
- Sub-module la_cellbist_seq holds the state register, idx and wait counters, and the drive registers.
- The top level holds the comparator, err_cnt, pass and the optional fail log.

## Test plan
- Good cell: ideal OA31 model, SETTLE=2, start at T -> done=1 at T+49, err_cnt=0, pass=1; drive sequence 0..15, each held 3 cycles.
- Stuck-at-0 z -> err_cnt=7 (patterns 9..15), pass=0; with FAILLOG fail_idx=9, fail_z=0.
- Stuck-at-1 z -> err_cnt=9, pass=0; with FAILLOG fail_idx=0, fail_z=1.
- start pulsed at cycles 5, 20 and 40 of a sweep -> ignored; done still at T+49. start in DONE -> done drops next cycle, new sweep gives an identical result.
- reset asserted at pattern 6 -> next cycle all outputs 0, state IDLE; following start runs a full 16-pattern sweep with err_cnt from 0.
- SETTLE=1 and SETTLE=15 with TRUTH=16'h8000 and an AND4 model -> pass=1, done at T+33 and T+257 respectively.
